// File: rtl/pwm_pkg.sv
// Shared register map and channel configuration record for the multi-channel
// Avalon PWM peripheral.
package pwm_pkg;

    localparam int REG_PRESCALE = 0;
    localparam int REG_ENABLE   = 1;
    localparam int REG_POLARITY = 2;
    localparam int REG_STATUS   = 3;
    localparam int REG_CH_BASE  = 4;
    localparam int CH_STRIDE    = 2;

    // Config fields are bus-wide; bits above the counter width are always stored as 0.
    localparam int CFG_W = 32;

    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] duty;
    } ch_cfg_t;

    // Keep only the low w bits of a bus word.
    function automatic logic [CFG_W-1:0] low_bits(input logic [CFG_W-1:0] d, input int w);
        logic [CFG_W-1:0] m;
        m = {CFG_W{1'b0}};
        for (int i = 0; i < CFG_W; i++) begin
            m[i] = (i < w);
        end
        return d & m;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: period counter, double-buffered period/duty shadows,
// compare and registered output with polarity.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    input  logic             pol,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm,
    output logic             wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per_sh;
    logic [CNT_W-1:0] r_duty_sh;
    logic             r_pwm;

    logic w_zero_per;
    logic w_last;
    logic w_act;

    // Compare and wrap detection against the shadow values.
    always_comb begin
        w_zero_per = (r_per_sh == {CNT_W{1'b0}});
        w_last     = !w_zero_per && (r_cnt == (r_per_sh - CNT_W'(1)));
        w_act      = en && !w_zero_per && (r_cnt < r_duty_sh);
        wrap       = en && tick && w_last;
    end

    // Counter and shadows: shadows follow the registers while disabled,
    // and reload only at a period boundary while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_per_sh  <= {CNT_W{1'b0}};
            r_duty_sh <= {CNT_W{1'b0}};
        end else if (!en) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_per_sh  <= period;
            r_duty_sh <= duty;
        end else if (tick) begin
            if (w_zero_per || w_last) begin
                r_cnt     <= {CNT_W{1'b0}};
                r_per_sh  <= period;
                r_duty_sh <= duty;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Output flop; an inactive channel sits at its polarity level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_act ^ pol;
        end
    end

    assign pwm = r_pwm;

endmodule

// File: rtl/avalon_pwm_multi.sv
// Avalon-MM slave driving N_CH PWM channels from one shared prescaler:
// address decode, register file, prescaler, sticky STATUS and registered read mux.
module avalon_pwm_multi
    import pwm_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int CNT_W  = 16,
    parameter  int PRE_W  = 16,
    localparam int ADDR_W = $clog2(4 + 2 * N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [N_CH-1:0]   pwm_out
);

    localparam int N_REGS = REG_CH_BASE + CH_STRIDE * N_CH;

    logic [PRE_W-1:0] r_prescale;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [N_CH-1:0]  r_enable;
    logic [N_CH-1:0]  r_polarity;
    logic [N_CH-1:0]  r_status;
    ch_cfg_t          r_cfg [N_CH];
    logic [31:0]      r_readdata;

    logic              w_wr;
    logic              w_rd;
    logic              w_pre_wr;
    logic              w_tick;
    logic              w_ch_hit;
    logic              w_is_duty;
    logic [ADDR_W-1:0] w_ch_off;
    logic [ADDR_W-2:0] w_ch_idx;
    logic [N_CH-1:0]   w_clr;
    logic [N_CH-1:0]   w_wrap;
    logic [N_CH-1:0]   w_pwm;
    logic [N_CH-1:0]   w_ch_sel;
    logic [31:0]       w_ch_rdata;
    logic [31:0]       w_rdata;

    // Bus decode; channel registers come in period/duty pairs above the base.
    always_comb begin
        w_wr      = chipselect && !write_n;
        w_rd      = chipselect && !read_n;
        w_ch_off  = address - ADDR_W'(REG_CH_BASE);
        w_ch_idx  = w_ch_off[ADDR_W-1:1];
        w_is_duty = w_ch_off[0];
        w_ch_hit  = (int'(address) >= REG_CH_BASE) && (int'(address) < N_REGS);
        w_pre_wr  = w_wr && (address == ADDR_W'(REG_PRESCALE));
        w_tick    = (r_pre_cnt == r_prescale);
        w_clr     = (w_wr && (address == ADDR_W'(REG_STATUS))) ? writedata[N_CH-1:0]
                                                               : {N_CH{1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            w_ch_sel[k] = w_ch_hit && (w_ch_idx == (ADDR_W-1)'(k));
        end
    end

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        w_ch_rdata = 32'd0;
        for (int k = 0; k < N_CH; k++) begin
            w_ch_rdata = w_ch_rdata | ({32{w_ch_sel[k]}} &
                         (w_is_duty ? r_cfg[k].duty : r_cfg[k].period));
        end
        case (int'(address))
            REG_PRESCALE: w_rdata = 32'(r_prescale);
            REG_ENABLE:   w_rdata = 32'(r_enable);
            REG_POLARITY: w_rdata = 32'(r_polarity);
            REG_STATUS:   w_rdata = 32'(r_status);
            default:      w_rdata = w_ch_hit ? w_ch_rdata : 32'd0;
        endcase
    end

    // Shared prescaler; a PRESCALE write restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= {PRE_W{1'b0}};
            r_pre_cnt  <= {PRE_W{1'b0}};
        end else if (w_pre_wr) begin
            r_prescale <= writedata[PRE_W-1:0];
            r_pre_cnt  <= {PRE_W{1'b0}};
        end else if (w_tick) begin
            r_pre_cnt  <= {PRE_W{1'b0}};
        end else begin
            r_pre_cnt  <= r_pre_cnt + PRE_W'(1);
        end
    end

    // Control and per-channel configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable   <= {N_CH{1'b0}};
            r_polarity <= {N_CH{1'b0}};
            for (int k = 0; k < N_CH; k++) begin
                r_cfg[k] <= {(2 * CFG_W){1'b0}};
            end
        end else begin
            if (w_wr && (address == ADDR_W'(REG_ENABLE))) begin
                r_enable <= writedata[N_CH-1:0];
            end
            if (w_wr && (address == ADDR_W'(REG_POLARITY))) begin
                r_polarity <= writedata[N_CH-1:0];
            end
            for (int k = 0; k < N_CH; k++) begin
                if (w_wr && w_ch_sel[k]) begin
                    if (w_is_duty) begin
                        r_cfg[k].duty <= low_bits(writedata, CNT_W);
                    end else begin
                        r_cfg[k].period <= low_bits(writedata, CNT_W);
                    end
                end
            end
        end
    end

    // Sticky period-end flags; a set in the same clock as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status <= {N_CH{1'b0}};
        end else begin
            r_status <= (r_status & ~w_clr) | w_wrap;
        end
    end

    // Read data register, updated only by a read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= 32'd0;
        end else if (w_rd) begin
            r_readdata <= w_rdata;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .tick   (w_tick),
            .en     (r_enable[k]),
            .pol    (r_polarity[k]),
            .period (r_cfg[k].period[CNT_W-1:0]),
            .duty   (r_cfg[k].duty[CNT_W-1:0]),
            .pwm    (w_pwm[k]),
            .wrap   (w_wrap[k])
        );
    end

    assign pwm_out  = w_pwm;
    assign readdata = r_readdata;

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// Scoreboard bench for avalon_pwm_multi: expected words are queued as stimulus
// is driven and popped when the matching read data or PWM sample appears.
module tb_avalon_pwm_multi;

    logic        clk;
    logic        reset;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [3:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  pwm_out;

    int total;
    int bad;
    logic [31:0] sb_q[$];

    avalon_pwm_multi #(
        .N_CH  (4),
        .CNT_W (16),
        .PRE_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .pwm_out    (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic push_n(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(v);
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [3:0] a, input logic [31:0] exp);
        sb_q.push_back(exp);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1;
        chk($sformatf("rd_a%0d", a), readdata, sb_q.pop_front());
    endtask

    // Sample pwm_out after each of n edges, optionally writing on edge wr_at.
    task automatic run_vec(input string tag, input int n, input int wr_at,
                           input logic [3:0] wa, input logic [31:0] wd);
        for (int i = 0; i < n; i++) begin
            if (i == wr_at) begin
                chipselect = 1'b1; write_n = 1'b0; address = wa; writedata = wd;
            end
            @(posedge clk); #1;
            chipselect = 1'b0; write_n = 1'b1;
            chk($sformatf("%s_%0d", tag, i), 32'(pwm_out), sb_q.pop_front());
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        total = 0; bad = 0;
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        address = 4'd0; writedata = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_rd", readdata, 32'd0);

        // Basic waveform, STATUS set and W1C clear.
        bus_wr(4'd4, 32'd10);
        bus_wr(4'd5, 32'd3);
        bus_wr(4'd1, 32'd1);
        for (int r = 0; r < 2; r++) begin
            push_n(32'd1, 3);
            push_n(32'd0, 7);
        end
        run_vec("t2_wave", 20, -1, 4'd0, 32'd0);
        bus_rd(4'd3, 32'd1);
        bus_wr(4'd3, 32'd1);
        bus_rd(4'd3, 32'd0);

        // Asynchronous reset in the middle of a high phase.
        bus_rd(4'd4, 32'd10);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            found = pwm_out[0];
        end
        chk("t1_pre_hi", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t1_pwm_async", 32'(pwm_out), 32'd0);
        chk("t1_rd_async", readdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int a = 0; a < 12; a++) bus_rd(4'(a), 32'd0);

        // Double buffering: mid-period write, then a write on the wrap edge.
        bus_wr(4'd4, 32'd10);
        bus_wr(4'd5, 32'd3);
        bus_wr(4'd1, 32'd1);
        push_n(32'd1, 3); push_n(32'd0, 6);
        run_vec("t3_a", 9, 5, 4'd5, 32'd8);
        push_n(32'd0, 1); push_n(32'd1, 8); push_n(32'd0, 2);
        run_vec("t3_b", 11, 10, 4'd5, 32'd2);
        push_n(32'd1, 8); push_n(32'd0, 2); push_n(32'd1, 2); push_n(32'd0, 8);
        run_vec("t3_c", 20, -1, 4'd0, 32'd0);
        bus_rd(4'd5, 32'd2);

        // Boundary duty/period values.
        do_reset();
        bus_wr(4'd6, 32'd10);
        bus_wr(4'd7, 32'd0);
        bus_wr(4'd8, 32'd10);
        bus_wr(4'd9, 32'd20);
        bus_wr(4'd10, 32'd0);
        bus_wr(4'd11, 32'd5);
        bus_wr(4'd1, 32'hE);
        push_n(32'h4, 26);
        run_vec("t4_wave", 26, -1, 4'd0, 32'd0);
        bus_rd(4'd3, 32'h6);

        // Prescaler, active-low polarity, then disable.
        do_reset();
        bus_wr(4'd0, 32'd4);
        bus_wr(4'd2, 32'd2);
        bus_wr(4'd6, 32'd4);
        bus_wr(4'd7, 32'd1);
        bus_wr(4'd1, 32'd2);
        push_n(32'd0, 1);
        for (int r = 0; r < 2; r++) begin
            push_n(32'd2, 15);
            push_n(32'd0, 5);
        end
        run_vec("t5_wave", 41, -1, 4'd0, 32'd0);
        push_n(32'd2, 11);
        run_vec("t5_dis", 11, 0, 4'd1, 32'd0);
        bus_rd(4'd3, 32'h2);

        // Unmapped addresses and read latency.
        bus_rd(4'd6, 32'd4);
        bus_wr(4'd15, 32'hFFFF_FFFF);
        bus_wr(4'd12, 32'hFFFF_FFFF);
        sb_q.push_back(32'd0);
        chipselect = 1'b1; read_n = 1'b0; address = 4'd15;
        @(negedge clk);
        chk("t6_before_edge", readdata, 32'd4);
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1;
        chk("t6_rd15", readdata, sb_q.pop_front());
        @(posedge clk); #1;
        chk("t6_hold", readdata, 32'd0);
        bus_rd(4'd12, 32'd0);
        bus_rd(4'd0, 32'd4);
        bus_rd(4'd1, 32'd0);
        bus_rd(4'd2, 32'd2);
        bus_rd(4'd7, 32'd1);
        bus_wr(4'd8, 32'hABCD_1234);
        bus_rd(4'd8, 32'h0000_1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
